// File: rtl/systolic_operand_feeder.sv
// Operand feeder for a 2x2 output-stationary systolic array: buffers one pending
// operand pair and streams the active pair onto the array edges with diagonal skew.
module systolic_operand_feeder #(
  parameter int OP_WIDTH     = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*OP_WIDTH-1:0] in_a,
  input  logic [4*OP_WIDTH-1:0] in_b,
  output logic [OP_WIDTH-1:0]   a_row0,
  output logic [OP_WIDTH-1:0]   a_row1,
  output logic [OP_WIDTH-1:0]   b_col0,
  output logic [OP_WIDTH-1:0]   b_col1,
  output logic [1:0]            a_vld,
  output logic [1:0]            b_vld,
  output logic                  clear_acc,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [2:0]            state;
  logic [1:0]            t;
  logic [3:0]            drain_cnt;
  logic                  pend_full;
  logic [4*OP_WIDTH-1:0] pend_a, pend_b;
  logic [4*OP_WIDTH-1:0] act_a, act_b;

  function automatic logic [OP_WIDTH-1:0] elem(input logic [4*OP_WIDTH-1:0] m,
                                              input int unsigned idx);
    return m[idx*OP_WIDTH +: OP_WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the capture and the IDLE transfer below both read the old pend_full.
    if (reset) begin
      state     <= IDLE;
      t         <= 2'd0;
      drain_cnt <= 4'd0;
      pend_full <= 1'b0;
      // NOTE: operand registers are cleared too, so no stale or X data can ever
      // reach the array edge after reset.
      pend_a    <= '0;
      pend_b    <= '0;
      act_a     <= '0;
      act_b     <= '0;
    end else begin
      if (in_valid && !pend_full) begin
        pend_a    <= in_a;
        pend_b    <= in_b;
        pend_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pend_full) begin
            act_a     <= pend_a;
            act_b     <= pend_b;
            pend_full <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          t     <= 2'd0;
          state <= FEED;
        end
        FEED: begin
          if (t == 2'd2) begin
            t         <= 2'd0;
            drain_cnt <= 4'd0;
            state     <= DRAIN;
          end else begin
            t <= t + 2'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= DONE;
          else drain_cnt <= drain_cnt + 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of registered state; element index is 2*row+col.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    in_ready  = ~pend_full;
    busy      = (state != IDLE);
    clear_acc = (state == CLEAR);
    done      = (state == DONE);
    a_row0    = '0;
    a_row1    = '0;
    b_col0    = '0;
    b_col1    = '0;
    a_vld     = 2'b00;
    b_vld     = 2'b00;
    if (state == FEED) begin
      case (t)
        2'd0: begin
          a_row0 = elem(act_a, 0);
          b_col0 = elem(act_b, 0);
          a_vld  = 2'b01;
          b_vld  = 2'b01;
        end
        2'd1: begin
          a_row0 = elem(act_a, 1);
          a_row1 = elem(act_a, 2);
          b_col0 = elem(act_b, 2);
          b_col1 = elem(act_b, 1);
          a_vld  = 2'b11;
          b_vld  = 2'b11;
        end
        2'd2: begin
          a_row1 = elem(act_a, 3);
          b_col1 = elem(act_b, 3);
          a_vld  = 2'b10;
          b_vld  = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: job-phase reference model checked every cycle,
// table-driven single jobs, and directed back-to-back, backpressure and reset-abort runs.
module tb_systolic_operand_feeder;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4*W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] a_row0, a_row1, b_col0, b_col1;
  logic [1:0]   a_vld, b_vld;
  logic         clear_acc, busy, done;

  systolic_operand_feeder #(.OP_WIDTH(W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a_row0(a_row0), .a_row1(a_row1),
    .b_col0(b_col0), .b_col1(b_col1), .a_vld(a_vld), .b_vld(b_vld),
    .clear_acc(clear_acc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is a phase count p since its clear cycle.
  // p=0 clear, p=1..3 feed steps t=p-1, then D drain cycles, p=4+D done.
  bit             m_pend_full, m_act, m_take, m_start;
  int             m_p;
  logic [4*W-1:0] m_pend_a, m_pend_b, m_act_a, m_act_b;

  always @(posedge clk) begin
    if (reset) begin
      m_pend_full = 0; m_act = 0; m_p = 0;
      m_pend_a = '0; m_pend_b = '0; m_act_a = '0; m_act_b = '0;
    end else begin
      m_take  = in_valid && !m_pend_full;
      m_start = !m_act && m_pend_full;
      if (m_act) begin
        if (m_p == 4 + D) m_act = 0;
        else m_p++;
      end else if (m_start) begin
        m_act = 1; m_p = 0;
        m_act_a = m_pend_a; m_act_b = m_pend_b;
        m_pend_full = 0;
      end
      if (m_take) begin
        m_pend_a = in_a; m_pend_b = in_b; m_pend_full = 1;
      end
    end
  end

  function automatic logic [39:0] model_bundle();
    logic [1:0]   av = 2'b00, bv = 2'b00;
    logic [W-1:0] ar [2];
    logic [W-1:0] bc [2];
    int tt, d;
    ar[0] = '0; ar[1] = '0; bc[0] = '0; bc[1] = '0;
    if (m_act && m_p >= 1 && m_p <= 3) begin
      tt = m_p - 1;
      for (int i = 0; i < 2; i++) begin
        d = tt - i;
        if (d >= 0 && d <= 1) begin
          ar[i] = m_act_a[(2*i+d)*W +: W];
          av[i] = 1'b1;
        end
      end
      for (int j = 0; j < 2; j++) begin
        d = tt - j;
        if (d >= 0 && d <= 1) begin
          bc[j] = m_act_b[(2*d+j)*W +: W];
          bv[j] = 1'b1;
        end
      end
    end
    return {!m_pend_full, m_act, (m_act && m_p == 4 + D), (m_act && m_p == 0),
            av, bv, ar[0], ar[1], bc[0], bc[1]};
  endfunction

  function automatic logic [39:0] dut_bundle();
    return {in_ready, busy, done, clear_acc, a_vld, b_vld, a_row0, a_row1, b_col0, b_col1};
  endfunction

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) check("model", 64'(dut_bundle()), 64'(model_bundle()));

  typedef struct packed {
    logic [31:0]       a, b;
    logic [2:0][7:0]   a0, a1, b0, b1;
    logic [2:0][1:0]   av, bv;
    logic [3:0][31:0]  c;
  } vec_t;
  vec_t vecs [3];

  logic [W-1:0] a_s [2][3];
  logic [W-1:0] b_s [2][3];

  // Downstream 2x2 array: PE(i,j) sees row i delayed by j and column j delayed by i.
  function automatic int unsigned array_c(int i, int j);
    int unsigned sum = 0;
    int ia, ib;
    for (int s = 0; s < 5; s++) begin
      ia = s - j; ib = s - i;
      if (ia >= 0 && ia <= 2 && ib >= 0 && ib <= 2)
        sum += int'(a_s[i][ia]) * int'(b_s[j][ib]);
    end
    return sum;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v = vecs[k];
    int tt;
    wait_ready();
    in_valid = 1'b1; in_a = v.a; in_b = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    for (int n = 0; n <= 5 + D; n++) begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(n >= 1));
      check("clear_acc", 64'(clear_acc), 64'(n == 1));
      check("done", 64'(done), 64'(n == 5 + D));
      if (n >= 2 && n <= 4) begin
        tt = n - 2;
        check("feed", 64'({a_vld, b_vld, a_row0, a_row1, b_col0, b_col1}),
              64'({v.av[tt], v.bv[tt], v.a0[tt], v.a1[tt], v.b0[tt], v.b1[tt]}));
        a_s[0][tt] = a_row0; a_s[1][tt] = a_row1;
        b_s[0][tt] = b_col0; b_s[1][tt] = b_col1;
      end
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check("result", 64'(array_c(i, j)), 64'(v.c[2*i+j]));
    tick();
  endtask

  initial begin
    logic [31:0] x2a, x2b;
    vecs[0].a  = 32'h0403_0201; vecs[0].b  = 32'h0807_0605;
    vecs[0].a0 = {8'd0, 8'd2, 8'd1}; vecs[0].a1 = {8'd4, 8'd3, 8'd0};
    vecs[0].b0 = {8'd0, 8'd7, 8'd5}; vecs[0].b1 = {8'd8, 8'd6, 8'd0};
    vecs[0].c  = {32'd50, 32'd43, 32'd22, 32'd19};
    vecs[1].a  = 32'h281E_140A; vecs[1].b  = 32'h0403_0201;
    vecs[1].a0 = {8'd0, 8'd20, 8'd10}; vecs[1].a1 = {8'd40, 8'd30, 8'd0};
    vecs[1].b0 = {8'd0, 8'd3, 8'd1};   vecs[1].b1 = {8'd4, 8'd2, 8'd0};
    vecs[1].c  = {32'd220, 32'd150, 32'd100, 32'd70};
    vecs[2].a  = 32'hFFFF_FFFF; vecs[2].b  = 32'hFFFF_FFFF;
    vecs[2].a0 = {8'h00, 8'hFF, 8'hFF}; vecs[2].a1 = {8'hFF, 8'hFF, 8'h00};
    vecs[2].b0 = {8'h00, 8'hFF, 8'hFF}; vecs[2].b1 = {8'hFF, 8'hFF, 8'h00};
    vecs[2].c  = {32'd130050, 32'd130050, 32'd130050, 32'd130050};
    for (int k = 0; k < 3; k++) begin
      vecs[k].av = {2'b10, 2'b11, 2'b01};
      vecs[k].bv = {2'b10, 2'b11, 2'b01};
    end

    // Reset state, with junk on the inputs
    reset = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    tick(); tick();
    @(negedge clk);
    check("reset_outs", 64'(dut_bundle()), 64'h80_0000_0000);
    tick();
    in_valid = 1'b0; reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("post_reset_outs", 64'(dut_bundle()), 64'h80_0000_0000);
    tick();

    for (int k = 0; k < 3; k++) run_vec(k);

    // Back-to-back with backpressure: second pair captured at edge 3, then junk held on inputs
    wait_ready();
    x2a = 32'h4433_2211; x2b = 32'h8877_6655;
    in_valid = 1'b1; in_a = 32'h0403_0201; in_b = 32'h0807_0605;
    @(posedge clk); #1;
    for (int n = 0; n <= 15; n++) begin
      if (n == 2)                begin in_valid = 1'b1; in_a = x2a; in_b = x2b; end
      else if (n >= 3 && n <= 8) begin in_valid = 1'b1; in_a = $urandom; in_b = $urandom; end
      else                       begin in_valid = 1'b0; end
      @(negedge clk);
      if (n == 2) check("b2b_ready_free", 64'(in_ready), 64'd1);
      if (n >= 3 && n <= 8) check("b2b_ready_held", 64'(in_ready), 64'd0);
      if (n == 7) check("b2b_done1", 64'(done), 64'd1);
      if (n == 8) check("b2b_idle_gap", 64'({busy, clear_acc}), 64'd0);
      if (n == 9) check("b2b_clear2", 64'({clear_acc, in_ready}), 64'b11);
      if (n == 10) check("b2b_data2", 64'({a_row0, b_col0}), 64'({x2a[7:0], x2b[7:0]}));
      if (n == 11) check("b2b_data2_t1",
                         64'({a_row0, a_row1, b_col0, b_col1}),
                         64'({x2a[15:8], x2a[23:16], x2b[23:16], x2b[15:8]}));
      if (n == 15) check("b2b_done2", 64'(done), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tick();

    // Reset at FEED t=1 with a pair pending: job aborted, pair discarded
    wait_ready();
    in_valid = 1'b1; in_a = 32'h0403_0201; in_b = 32'h0807_0605;
    @(posedge clk); #1;
    for (int n = 0; n <= 20; n++) begin
      in_valid = (n == 1);
      in_a = 32'hA5A5_A5A5;
      reset = (n == 3);
      @(negedge clk);
      if (n == 3) check("abort_t1", 64'({a_vld, b_vld}), 64'b1111);
      if (n == 4) check("abort_outs", 64'(dut_bundle()), 64'h80_0000_0000);
      if (n > 4) check("abort_quiet", 64'({busy, done}), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    // Random traffic against the model, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_a     = $urandom;
      in_b     = $urandom;
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder.md
SYSTOLIC_OPERAND_FEEDER -- requirements
Module: systolic_operand_feeder

Interface
REQ-001 Parameter OP_WIDTH, default 8, SHALL set the operand element width in bits.
REQ-002 Parameter DRAIN_CYCLES, default 2, range 1..15, SHALL set the number of idle cycles after the last operand wave.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_a/in_b hold a 2x2 operand pair.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 in_a, in_b  input  4*OP_WIDTH each  row-major 2x2 matrices; element [i][j] at bits (2i+j)*OP_WIDTH +: OP_WIDTH.
REQ-008 a_row0, a_row1  output  OP_WIDTH each  left-edge operands into array rows 0/1.
REQ-009 b_col0, b_col1  output  OP_WIDTH each  top-edge operands into array columns 0/1.
REQ-010 a_vld[1:0], b_vld[1:0]  output  2 each  per-lane valid (bit k = row k / column k).
REQ-011 clear_acc  output  1  one-cycle pulse that zeroes downstream accumulators.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse marking the end of a job.

Function
REQ-014 A handshake SHALL occur on a rising edge where in_valid && in_ready; the pair SHALL be captured into a one-entry pending buffer.
REQ-015 in_ready SHALL equal NOT pend_full and SHALL depend on no input combinationally.
REQ-016 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, DONE; all outputs SHALL be registered, i.e. decoded from registered state.
REQ-017 IDLE with pend_full SHALL move the pending pair into the active registers, clear pend_full, and enter CLEAR; otherwise IDLE SHALL hold.
REQ-018 CLEAR SHALL last 1 cycle with clear_acc=1, then enter FEED with step counter t=0.
REQ-019 FEED SHALL last exactly 3 cycles, t=0,1,2.
REQ-020 At step t, row i SHALL drive A[i][t-i] with a_vld[i]=1 when 0<=t-i<=1; otherwise it SHALL drive 0 with a_vld[i]=0.
REQ-021 At step t, column j SHALL drive B[t-j][j] with b_vld[j]=1 when 0<=t-j<=1; otherwise it SHALL drive 0 with b_vld[j]=0.
REQ-022 DRAIN SHALL last DRAIN_CYCLES cycles with all lanes at 0 and valids at 0, then enter DONE.
REQ-023 DONE SHALL last 1 cycle with done=1, then enter IDLE.
REQ-024 Job latency SHALL be fixed: a handshake at edge k gives clear_acc in cycle k+1, FEED in cycles k+2..k+4, and done in cycle k+5+DRAIN_CYCLES.
REQ-025 The pending buffer SHALL accept a new pair while a job is busy, so the next job starts in the cycle after IDLE is entered (one IDLE cycle between jobs).
REQ-026 When the pending buffer is full, in_valid SHALL be ignored and in_a/in_b SHALL NOT alter the captured data.
REQ-027 Active operands SHALL stay stable from CLEAR through DONE regardless of new handshakes.
REQ-028 Outputs SHALL never carry X: unused lanes SHALL drive 0.

Reset
REQ-029 On reset the FSM SHALL go to IDLE, pend_full=0, t=0, and active/pending data SHALL be 0.
REQ-030 During and after reset: in_ready=1 and busy=0; done, clear_acc, all valids and all lanes SHALL be 0.
REQ-031 Reset mid-job SHALL abort the job and discard any pending pair; no done SHALL follow.

Verification
REQ-032 Single job, A=[1,2;3,4], B=[5,6;7,8]:
- FEED t0: a_row0=1, b_col0=5, a_vld=01, b_vld=01.
- t1: a_row0=2, a_row1=3, b_col0=7, b_col1=6, all valids 11.
- t2: a_row1=4, b_col1=8, a_vld=10, b_vld=10.
- Downstream array result SHALL be [19,22;43,50].
REQ-033 Latency: handshake at edge 0 with DRAIN_CYCLES=2 -> clear_acc in cycle 1, FEED in 2..4, done in cycle 7, busy high in cycles 1..7.
REQ-034 Back-to-back: second pair offered during the first job -> accepted, in_ready=0 until the next IDLE->CLEAR edge; second clear_acc exactly 2 cycles after the first done.
REQ-035 Backpressure: pending full, in_valid=1 with changing data -> no capture; the second job's data equals the first accepted value.
REQ-036 Reset asserted during FEED t=1 -> next cycle all outputs 0, in_ready=1, no done ever pulses for the aborted job.
